// File: rtl/mcore_pkg.sv
// Shared definitions for the nonce-sweep mining core.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: sweep FSM state enum, hash width, default nonce width, and
// lane_lo() which gives the low bit index of lane k inside a packed
// multi-lane bus.
package mcore_pkg;

    localparam int HASH_W          = 256;
    localparam int NONCE_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EVAL  = 2'd3
    } state_t;

    // Low bit position of slice 'lane' in a bus of 'width'-bit slices.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/hash_lt_cmp.sv
// 256-bit unsigned hash < target comparator for one hash lane.
// Latency: combinational, 0 cycles.
// Backpressure: none; the result is qualified by the caller's lane ready.
//
// Ports:
//   i_hash   - lane hash result
//   i_target - difficulty threshold (MSB byte is [255:248])
//   o_lt     - 1 when i_hash is strictly below i_target
module hash_lt_cmp
    import mcore_pkg::*;
(
    input  logic [HASH_W-1:0] i_hash,
    input  logic [HASH_W-1:0] i_target,
    output logic              o_lt
);

    assign o_lt = (i_hash < i_target);

endmodule

// File: rtl/mcore_sweep.sv
// Nonce sweep controller: issues LANES consecutive nonces per batch, collects lane hashes, stops on hit/limit/abort.
// Latency: start -> o_h_start 1 cycle; last lane ready -> next o_h_start or o_done 2 cycles; abort -> o_done 1 cycle.
// Backpressure: none; lanes are fire-and-forget, starts while busy and ready pulses outside WAIT are dropped.
//
// Ports:
//   i_clk, i_reset                  - clock, synchronous active-high reset
//   i_start, i_abort                - sweep control pulses
//   i_nonce_base, i_iter_max        - sweep setup, sampled on an accepted start (iter_max 0 = unlimited)
//   i_target                        - hit threshold
//   o_h_start, o_h_nonce            - batch launch to the lanes, slice k = cur + k
//   i_h_ready, i_h_hash             - per-lane completion pulse and hash
//   o_busy, o_done                  - status and one-cycle completion pulse
//   o_found, o_found_nonce,
//   o_found_hash, o_batches         - sweep result, held until the next accepted start
module mcore_sweep
    import mcore_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int NONCE_W = NONCE_W_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [NONCE_W-1:0]        i_nonce_base,
    input  logic [31:0]               i_iter_max,
    input  logic [HASH_W-1:0]         i_target,
    output logic                      o_h_start,
    output logic [LANES*NONCE_W-1:0]  o_h_nonce,
    input  logic [LANES-1:0]          i_h_ready,
    input  logic [LANES*HASH_W-1:0]   i_h_hash,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_found,
    output logic [NONCE_W-1:0]        o_found_nonce,
    output logic [HASH_W-1:0]         o_found_hash,
    output logic [31:0]               o_batches
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                     state_q;
    logic [NONCE_W-1:0]         cur_q;
    logic [31:0]                iter_max_q;
    logic [31:0]                batches_q;
    logic [LANES-1:0]           mask_q;
    logic [LANES*NONCE_W-1:0]   nonce_q;
    logic                       h_start_q;
    logic                       done_q;
    logic                       found_q;
    logic [NONCE_W-1:0]         found_nonce_q;
    logic [HASH_W-1:0]          found_hash_q;

    // Batch hit record: lowest-indexed hitting lane seen so far.
    logic                       hit_q,       hit_d;
    logic [IDX_W-1:0]           hit_idx_q,   hit_idx_d;
    logic [NONCE_W-1:0]         hit_nonce_q, hit_nonce_d;
    logic [HASH_W-1:0]          hit_hash_q,  hit_hash_d;

    logic [LANES-1:0]           lane_lt;
    logic [LANES-1:0]           new_rdy;
    logic [LANES-1:0]           mask_d;
    logic [NONCE_W-1:0]         issue_cur;
    logic [LANES*NONCE_W-1:0]   issue_nonces;
    logic [31:0]                batches_inc;

    for (genvar g = 0; g < LANES; g++) begin : g_cmp
        hash_lt_cmp u_cmp (
            .i_hash   (i_h_hash[lane_lo(g, HASH_W) +: HASH_W]),
            .i_target (i_target),
            .o_lt     (lane_lt[g])
        );
    end

    // A lane already in the mask has reported for this batch; repeats are dropped.
    assign new_rdy     = i_h_ready & ~mask_q;
    assign mask_d      = mask_q | i_h_ready;
    assign batches_inc = batches_q + 32'd1;

    // Walk lanes high to low so the lowest hitting index of this cycle wins;
    // it only displaces an existing record if it has a lower index.
    always_comb begin
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        hit_nonce_d = hit_nonce_q;
        hit_hash_d  = hit_hash_q;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (new_rdy[k] && lane_lt[k] && (!hit_q || (IDX_W'(k) < hit_idx_q))) begin
                hit_d       = 1'b1;
                hit_idx_d   = IDX_W'(k);
                hit_nonce_d = nonce_q[lane_lo(k, NONCE_W) +: NONCE_W];
                hit_hash_d  = i_h_hash[lane_lo(k, HASH_W) +: HASH_W];
            end
        end
    end

    // Nonce base of the next batch: the start value from IDLE, else advance by one batch.
    always_comb begin
        issue_cur    = (state_q == ST_IDLE) ? i_nonce_base : (cur_q + NONCE_W'(LANES));
        issue_nonces = '0;
        for (int k = 0; k < LANES; k++) begin
            issue_nonces[lane_lo(k, NONCE_W) +: NONCE_W] = issue_cur + NONCE_W'(k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            iter_max_q    <= '0;
            batches_q     <= '0;
            mask_q        <= '0;
            nonce_q       <= '0;
            h_start_q     <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            hit_nonce_q   <= '0;
            hit_hash_q    <= '0;
        end else begin
            h_start_q <= 1'b0;
            done_q    <= 1'b0;
            if ((state_q != ST_IDLE) && i_abort) begin
                // Abort drops any in-flight batch result.
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
                found_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start && !i_abort) begin
                            cur_q         <= i_nonce_base;
                            nonce_q       <= issue_nonces;
                            iter_max_q    <= i_iter_max;
                            batches_q     <= '0;
                            found_q       <= 1'b0;
                            found_nonce_q <= '0;
                            found_hash_q  <= '0;
                            h_start_q     <= 1'b1;
                            state_q       <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        mask_q      <= '0;
                        hit_q       <= 1'b0;
                        hit_idx_q   <= '0;
                        hit_nonce_q <= '0;
                        hit_hash_q  <= '0;
                        state_q     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        mask_q      <= mask_d;
                        hit_q       <= hit_d;
                        hit_idx_q   <= hit_idx_d;
                        hit_nonce_q <= hit_nonce_d;
                        hit_hash_q  <= hit_hash_d;
                        if (&mask_d) begin
                            state_q <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        batches_q <= batches_inc;
                        if (hit_q) begin
                            found_q       <= 1'b1;
                            found_nonce_q <= hit_nonce_q;
                            found_hash_q  <= hit_hash_q;
                            done_q        <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else if ((iter_max_q != 32'd0) && (batches_inc == iter_max_q)) begin
                            found_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cur_q     <= issue_cur;
                            nonce_q   <= issue_nonces;
                            h_start_q <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_h_start     = h_start_q;
    assign o_h_nonce     = nonce_q;
    assign o_done        = done_q;
    assign o_found       = found_q;
    assign o_found_nonce = found_nonce_q;
    assign o_found_hash  = found_hash_q;
    assign o_batches     = batches_q;

endmodule

// File: tb/tb_mcore_sweep.sv
// Directed bench for mcore_sweep (LANES=2, NONCE_W=16) with a fixed-latency lane model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mcore_sweep;

    localparam int LN = 2;
    localparam int NW = 16;
    localparam int HW = 256;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_start;
    logic              i_abort;
    logic [NW-1:0]     i_nonce_base;
    logic [31:0]       i_iter_max;
    logic [HW-1:0]     i_target;
    logic              o_h_start;
    logic [LN*NW-1:0]  o_h_nonce;
    logic [LN-1:0]     i_h_ready;
    logic [LN*HW-1:0]  i_h_hash;
    logic              o_busy;
    logic              o_done;
    logic              o_found;
    logic [NW-1:0]     o_found_nonce;
    logic [HW-1:0]     o_found_hash;
    logic [31:0]       o_batches;

    mcore_sweep #(.LANES(LN), .NONCE_W(NW)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_nonce_base  (i_nonce_base),
        .i_iter_max    (i_iter_max),
        .i_target      (i_target),
        .o_h_start     (o_h_start),
        .o_h_nonce     (o_h_nonce),
        .i_h_ready     (i_h_ready),
        .i_h_hash      (i_h_hash),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_found       (o_found),
        .o_found_nonce (o_found_nonce),
        .o_found_hash  (o_found_hash),
        .o_batches     (o_batches)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int t0;
    int done_cyc;
    int ib;
    int dc;

    // Lane model state
    int            lat [LN];
    int            rem [LN];
    logic [NW-1:0] cap [LN];
    logic [LN*NW-1:0] issue_log [$];

    logic          hit_a_en, hit_b_en, eq_mode;
    logic [NW-1:0] hit_a, hit_b;
    logic [HW-1:0] hash_a, hash_b;
    logic [HW-1:0] tgt;

    function automatic logic [HW-1:0] model_hash(input logic [NW-1:0] n);
        if (hit_a_en && n == hit_a) return hash_a;
        if (hit_b_en && n == hit_b) return hash_b;
        if (eq_mode) return tgt;
        return '1;
    endfunction

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, then the lane model drives inputs.
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        i_h_ready = '0;
        i_h_hash  = '1;
        for (int k = 0; k < LN; k++) begin
            if (rem[k] != 0) begin
                rem[k]--;
                if (rem[k] == 0) begin
                    i_h_ready[k] = 1'b1;
                    i_h_hash[k*HW +: HW] = model_hash(cap[k]);
                end
            end
        end
        if (o_h_start) begin
            issue_log.push_back(o_h_nonce);
            for (int k = 0; k < LN; k++) begin
                rem[k] = lat[k];
                cap[k] = o_h_nonce[k*NW +: NW];
            end
        end
        if (o_done) done_cnt++;
    endtask

    task automatic start_sweep(input logic [NW-1:0] base, input logic [31:0] iters);
        i_nonce_base = base;
        i_iter_max   = iters;
        i_start      = 1'b1;
        t0           = cyc;
        ib           = issue_log.size();
        step();
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_done) break;
            step();
        end
        chk(tag, o_done, 1'b1);
        done_cyc = cyc;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_nonce_base = '0;
        i_iter_max   = '0;
        tgt          = {8'h00, {248{1'b1}}};
        i_target     = tgt;
        i_h_ready    = '0;
        i_h_hash     = '1;
        hit_a_en = 1'b0; hit_b_en = 1'b0; eq_mode = 1'b0;
        hit_a = '0; hit_b = '0; hash_a = '0; hash_b = '0;
        for (int k = 0; k < LN; k++) begin
            lat[k] = 4; rem[k] = 0; cap[k] = '0;
        end

        // Reset state
        repeat (3) step();
        chk("rst_busy",   o_busy, 1'b0);
        chk("rst_hstart", o_h_start, 1'b0);
        chk("rst_hnonce", o_h_nonce, '0);
        chk("rst_done",   o_done, 1'b0);
        chk("rst_found",  o_found, 1'b0);
        chk("rst_fnonce", o_found_nonce, '0);
        chk("rst_fhash",  o_found_hash, '0);
        chk("rst_batches", o_batches, '0);
        i_reset = 1'b0;
        repeat (10) step();
        chk("idle_issues", issue_log.size(), 0);
        chk("idle_busy",   o_busy, 1'b0);
        chk("idle_done",   done_cnt, 0);

        // Single batch, lane 1 (nonce 5) hits with hash 0
        hit_a_en = 1'b1; hit_a = 16'd5; hash_a = '0;
        start_sweep(16'd4, 32'd0);
        chk("t1_busy",   o_busy, 1'b1);
        chk("t1_hstart", o_h_start, 1'b1);
        chk("t1_hnonce", o_h_nonce, {16'd5, 16'd4});
        step();
        chk("t1_hstart_pulse", o_h_start, 1'b0);
        wait_done("t1_done", 40);
        chk("t1_latency", done_cyc - t0, 7);
        chk("t1_found",   o_found, 1'b1);
        chk("t1_fnonce",  o_found_nonce, 16'd5);
        chk("t1_fhash",   o_found_hash, '0);
        chk("t1_batches", o_batches, 32'd1);
        step();
        chk("t1_done_pulse", o_done, 1'b0);
        chk("t1_found_held", o_found, 1'b1);
        chk("t1_busy_after", o_busy, 1'b0);
        hit_a_en = 1'b0;

        // Batch limit of 3, every hash equal to target (never a hit)
        eq_mode = 1'b1;
        start_sweep(16'd0, 32'd3);
        chk("t2_found_cleared", o_found, 1'b0);
        chk("t2_fnonce_cleared", o_found_nonce, '0);
        wait_done("t2_done", 80);
        chk("t2_latency", done_cyc - t0, 19);
        chk("t2_found",   o_found, 1'b0);
        chk("t2_batches", o_batches, 32'd3);
        chk("t2_issues",  issue_log.size() - ib, 3);
        chk("t2_b0", issue_log[ib],     {16'd1, 16'd0});
        chk("t2_b1", issue_log[ib + 1], {16'd3, 16'd2});
        chk("t2_b2", issue_log[ib + 2], {16'd5, 16'd4});
        eq_mode = 1'b0;
        repeat (2) step();

        // Nonce wrap: base 0xFFFF, hit on nonce 2 in the second batch
        hit_a_en = 1'b1; hit_a = 16'd2; hash_a = '0;
        start_sweep(16'hFFFF, 32'd0);
        wait_done("t3_done", 80);
        chk("t3_latency", done_cyc - t0, 13);
        chk("t3_b0", issue_log[ib],     {16'h0000, 16'hFFFF});
        chk("t3_b1", issue_log[ib + 1], {16'h0002, 16'h0001});
        chk("t3_found",   o_found, 1'b1);
        chk("t3_fnonce",  o_found_nonce, 16'h0002);
        chk("t3_batches", o_batches, 32'd2);
        hit_a_en = 1'b0;
        repeat (2) step();

        // Both lanes hit: lane 1 at cycle 3 first, lane 0 at cycle 6 takes over
        lat[0] = 5; lat[1] = 2;
        hit_a_en = 1'b1; hit_a = 16'd10; hash_a = 256'h10;
        hit_b_en = 1'b1; hit_b = 16'd11; hash_b = 256'h20;
        start_sweep(16'd10, 32'd0);
        wait_done("t4_done", 40);
        chk("t4_latency", done_cyc - t0, 8);
        chk("t4_found",   o_found, 1'b1);
        chk("t4_fnonce",  o_found_nonce, 16'd10);
        chk("t4_fhash",   o_found_hash, 256'h10);
        chk("t4_batches", o_batches, 32'd1);
        hit_a_en = 1'b0; hit_b_en = 1'b0;
        lat[0] = 4; lat[1] = 4;
        repeat (2) step();

        // Abort in WAIT, with a busy start beforehand and late ready pulses after
        dc = done_cnt;
        start_sweep(16'd20, 32'd0);
        step();
        i_start = 1'b1; i_nonce_base = 16'd99;
        step();
        i_start = 1'b0;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("t5_abort_lat", cyc - t0, 4);
        chk("t5_done",    o_done, 1'b1);
        chk("t5_busy",    o_busy, 1'b0);
        chk("t5_found",   o_found, 1'b0);
        chk("t5_batches", o_batches, 32'd0);
        repeat (8) step();
        chk("t5_issues",  issue_log.size() - ib, 1);
        chk("t5_done_cnt", done_cnt - dc, 1);
        chk("t5_idle",    o_busy, 1'b0);

        // Start and abort together in IDLE: start is dropped
        dc = done_cnt;
        ib = issue_log.size();
        i_start = 1'b1; i_abort = 1'b1;
        step();
        i_start = 1'b0; i_abort = 1'b0;
        repeat (3) step();
        chk("t6_busy",   o_busy, 1'b0);
        chk("t6_issues", issue_log.size() - ib, 0);
        chk("t6_done",   done_cnt - dc, 0);

        // Reset mid-sweep: back to IDLE with no done pulse
        start_sweep(16'd40, 32'd0);
        step();
        dc = done_cnt;
        i_reset = 1'b1;
        step();
        chk("t7_busy",   o_busy, 1'b0);
        chk("t7_done",   o_done, 1'b0);
        chk("t7_hnonce", o_h_nonce, '0);
        i_reset = 1'b0;
        repeat (8) step();
        chk("t7_no_done", done_cnt - dc, 0);
        chk("t7_idle",    o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
